// File: rtl/alu_issue.sv
// Issue/writeback sequencer in front of a combinational ALU: decode, hold operands, capture result.
// Optional feature macro: ALU_ISSUE_MUL_EN enables the multi-cycle MUL path (MUL_LAT cycles).
module alu_issue #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    output logic [31:0] alu_data_a,
    output logic [31:0] alu_data_b,
    output logic [3:0]  alu_select,
    input  logic [31:0] alu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_err
);

    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
        $error("alu_issue: MUL_LAT must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_q, rd_d;
    logic        err_q, err_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  sel_q, sel_d;

    logic        dec_legal;
    logic [3:0]  dec_sel;
    logic [31:0] dec_b;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;

`ifdef ALU_ISSUE_MUL_EN
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
    logic        dec_mul;
    logic [3:0]  cnt_q, cnt_d;
`endif

    // Register indices arrive already resolved as rs1/rs2 values.
    logic unused_rs1_field;
    assign unused_rs1_field = ^in_instr[19:15];

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    always_comb begin
        dec_legal = 1'b0;
        dec_sel   = 4'b1111;
        dec_b     = in_rs2_val;
`ifdef ALU_ISSUE_MUL_EN
        dec_mul   = 1'b0;
`endif
        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: begin dec_legal = 1'b1; dec_sel = 4'b0010; end
                        3'b111: begin dec_legal = 1'b1; dec_sel = 4'b0000; end
                        3'b110: begin dec_legal = 1'b1; dec_sel = 4'b0001; end
                        3'b001: begin
                            dec_legal = 1'b1;
                            dec_sel   = 4'b0111;
                            dec_b     = {27'd0, in_rs2_val[4:0]};
                        end
                        default: ;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_sel   = 4'b0110;
                end
`ifdef ALU_ISSUE_MUL_EN
                else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_sel   = 4'b1100;
                    dec_mul   = 1'b1;
                end
`endif
            end
            OP_I: begin
                dec_b = {{20{in_instr[31]}}, in_instr[31:20]};
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_sel = 4'b0010; end
                    3'b111: begin dec_legal = 1'b1; dec_sel = 4'b0000; end
                    3'b110: begin dec_legal = 1'b1; dec_sel = 4'b0001; end
                    3'b001: begin
                        if (funct7 == 7'b0000000) begin
                            dec_legal = 1'b1;
                            dec_sel   = 4'b0111;
                            dec_b     = {27'd0, in_instr[24:20]};
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        rd_d     = rd_q;
        err_d    = err_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
`ifdef ALU_ISSUE_MUL_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rd_d = in_instr[11:7];
                    if (dec_legal) begin
                        a_d     = in_rs1_val;
                        b_d     = dec_b;
                        sel_d   = dec_sel;
                        state_d = EXEC;
`ifdef ALU_ISSUE_MUL_EN
                        cnt_d   = dec_mul ? MUL_CNT : 4'd1;
`endif
                    end else begin
                        result_d = 32'd0;
                        err_d    = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            EXEC: begin
`ifdef ALU_ISSUE_MUL_EN
                if (cnt_q == 4'd1) begin
                    result_d = (rd_q == 5'd0) ? 32'd0 : alu_result;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
`else
                result_d = (rd_q == 5'd0) ? 32'd0 : alu_result;
                err_d    = 1'b0;
                state_d  = RESP;
`endif
            end
            RESP: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake flags are registered copies of the next state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
            rd_q        <= 5'd0;
            err_q       <= 1'b0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            sel_q       <= 4'b1111;
`ifdef ALU_ISSUE_MUL_EN
            cnt_q       <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
`ifdef ALU_ISSUE_MUL_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign out_rd     = rd_q;
    assign out_err    = err_q;
    assign alu_data_a = a_q;
    assign alu_data_b = b_q;
    assign alu_select = sel_q;

endmodule

// File: doc/alu_issue.md
# alu_issue

Multi-cycle issue and writeback sequencer that drives the combinational ALU from the decode side. Accepts a 32-bit RV32 instruction plus register operands through a valid/ready handshake. Decodes the instruction into the ALU select code and registered operands, waits the required execute cycles, and captures the ALU result. Presents the result with its destination register to writeback through a second valid/ready handshake.

## Interface
- MUL_LAT, 2, execute cycles held for MUL before the result is sampled; legal range 1..15.
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous assert and active-low; synchronous deassert is provided externally.
- in_valid  in  1  instruction and operands valid.
- in_ready  out  1  sequencer can accept; high only in IDLE.
- in_instr  in  32  instruction word.
- in_rs1_val  in  32  rs1 value.
- in_rs2_val  in  32  rs2 value.
- alu_data_a  out  32  registered ALU operand A.
- alu_data_b  out  32  registered ALU operand B.
- alu_select  out  4  registered ALU select code.
- alu_result  in  32  combinational ALU result.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback accepts the result.
- out_result  out  32  captured result.
- out_rd  out  5  destination register (instr[11:7]).
- out_err  out  1  illegal or unsupported instruction.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch rd and decode.
  - Legal instruction: load alu_data_a/alu_data_b/alu_select, go to EXEC.
  - Illegal instruction: load out_result=0, out_err=1, go directly to RESP.
- Decode, opcode 0110011 (R-type), by funct7/funct3:
  - 0000000/000 add -> 4'b0010
  - 0100000/000 sub -> 4'b0110
  - 0000000/111 and -> 4'b0000
  - 0000000/110 or -> 4'b0001
  - 0000000/001 sll -> 4'b0111
  - 0000001/000 mul -> 4'b1100
- Decode, opcode 0010011 (I-type):
  - funct3 000 addi, 111 andi, 110 ori: alu_data_b = sign-extended instr[31:20].
  - funct3 001 slli: requires instr[31:25]=0; alu_data_b = zero-extended instr[24:20].
- Any other opcode/funct combination is illegal.
- Shift operand: for sll, alu_data_b is masked to bits [4:0], upper bits 0.
- alu_data_a is always rs1.
- EXEC:
  - 4-bit counter, loaded with 1 for non-MUL and MUL_LAT for MUL; decrements each cycle.
  - When counter==1, sample alu_result into out_result, out_err=0, go to RESP.
- RESP:
  - out_valid=1. out_result, out_rd and out_err are held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
- rd==0: out_result forced to 0; out_err unaffected.
- ALU drive registers hold their last values outside EXEC.
- Reset asserted mid-operation (EXEC or RESP) aborts the operation. No response is issued for it.

## Timing
- Reset values:
  - in_ready=1 once in IDLE.
  - out_valid=0, out_result=0, out_rd=0, out_err=0.
  - alu_data_a=0, alu_data_b=0, alu_select=4'b1111.
- Handshake accepted at edge E0:
  - Non-MUL: EXEC for 1 cycle; out_valid high from edge E0+2.
  - MUL: EXEC for MUL_LAT cycles; out_valid from E0+MUL_LAT+1.
  - Illegal: out_valid from E0+1.
- out_ready high in the first RESP cycle: in_ready is high on the following cycle. Minimum non-MUL throughput is one instruction per 3 cycles.
- out_ready is allowed to be high before out_valid. Only the coincidence of both completes a transfer.
- No input accepted while busy: in_valid in EXEC/RESP is ignored, and in_instr is not sampled.
- Arithmetic: all 32-bit, wrap-around, no overflow flag. mul returns the low 32 bits.

## Configuration
- ALU_ISSUE_MUL_EN defined: mul decodes to 4'b1100 and uses the MUL_LAT execute cycles.
- ALU_ISSUE_MUL_EN undefined: funct7 0000001 is illegal (out_err=1, result 0, latency 1). MUL_LAT is unused and the multi-cycle count path is removed.

## Test plan
- add x5,x1,x2 with rs1=7, rs2=0xFFFFFFFF -> out_valid at E0+2, out_result=6, out_rd=5, out_err=0, alu_select=4'b0010 during EXEC.
- sub x3 with rs1=0, rs2=1 -> 0xFFFFFFFF. sll x4 with rs1=1, rs2=0x00000025 -> alu_data_b=5, result 0x20.
- addi x6,x1,-1 (imm 0xFFF) with rs1=0 -> 0xFFFFFFFF. slli with instr[31:25]=0100000 -> out_err=1, out_result=0, out_valid at E0+1.
- mul x7 with rs1=0x10000, rs2=0x10000, MUL_LAT=3, macro defined -> out_valid at E0+4, result 0. Macro undefined -> out_err=1.
- Hold out_ready=0 for 5 cycles in RESP -> outputs stable, in_ready=0. Concurrent in_valid is ignored, and the next op is accepted only after the transfer.
- Assert rst_n low during EXEC -> out_valid=0 immediately, state IDLE, alu_select=4'b1111. add x0 -> out_result=0.
